// File: rtl/axis_trigger_sequencer.sv
// Acquisition sequencer: gates an AXI4-Stream sample path into a ring-buffer
// writer, with a pre-trigger window, an armed phase and a post-trigger window.
// Records the ring address of the trigger sample and reports the capture status.
module axis_trigger_sequencer #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 16
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        run_flag,
    input  logic                        trg_flag,
    input  logic [CNTR_WIDTH-1:0]       pre_data,
    input  logic [CNTR_WIDTH-1:0]       tot_data,
    output logic [CNTR_WIDTH-1:0]       sts_data,
    output logic [CNTR_WIDTH-1:0]       cnt_data,
    output logic                        armed,
    output logic                        busy,
    output logic                        done,
    output logic                        s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ARMED,
        S_POST,
        S_DONE
    } state_t;

    localparam logic [CNTR_WIDTH-1:0] ONE = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic                  run_q, run_d;
    logic [CNTR_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNTR_WIDTH-1:0] sts_q, sts_d;
    logic [CNTR_WIDTH-1:0] win_q, win_d;
    logic [CNTR_WIDTH-1:0] pre_len_q, pre_len_d;
    logic [CNTR_WIDTH-1:0] post_len_q, post_len_d;
    logic                  armed_q, armed_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  capturing;
    logic                  acc;
    logic                  start;
    logic [CNTR_WIDTH-1:0] cnt_inc;
    logic [CNTR_WIDTH-1:0] win_inc;

    // Zero-latency datapath: forward while capturing, drain and drop otherwise
    always_comb begin
        capturing     = (state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST);
        m_axis_tdata  = s_axis_tdata;
        m_axis_tvalid = s_axis_tvalid && capturing;
        s_axis_tready = capturing ? m_axis_tready : 1'b1;
        acc           = s_axis_tvalid && s_axis_tready && capturing;
        start         = run_flag && !run_q;
        cnt_inc       = cnt_q + ONE;
        win_inc       = win_q + ONE;
    end

    // Next-state and counter logic for the capture sequence
    always_comb begin
        state_d    = state_q;
        run_d      = run_flag;
        cnt_d      = cnt_q;
        sts_d      = sts_q;
        win_d      = win_q;
        pre_len_d  = pre_len_q;
        post_len_d = post_len_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    cnt_d      = '0;
                    win_d      = '0;
                    pre_len_d  = pre_data;
                    post_len_d = (tot_data > pre_data) ? (tot_data - pre_data) : ONE;
                    state_d    = (pre_data == '0) ? S_ARMED : S_PRE;
                end
            end
            S_PRE: begin
                if (acc) begin
                    cnt_d = cnt_inc;
                    if (win_inc == pre_len_q) begin
                        win_d   = '0;
                        state_d = S_ARMED;
                    end else begin
                        win_d = win_inc;
                    end
                end
            end
            S_ARMED: begin
                if (acc) begin
                    cnt_d = cnt_inc;
                    if (trg_flag) begin
                        sts_d   = cnt_q;
                        win_d   = ONE;
                        state_d = (post_len_q == ONE) ? S_DONE : S_POST;
                    end
                end
            end
            S_POST: begin
                if (acc) begin
                    cnt_d = cnt_inc;
                    win_d = win_inc;
                    if (win_inc == post_len_q) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides every transition and freezes counters and trigger address
        if (capturing && !run_flag) begin
            state_d = S_IDLE;
            cnt_d   = cnt_q;
            win_d   = win_q;
            sts_d   = sts_q;
        end

        armed_d = (state_d == S_ARMED);
        busy_d  = (state_d == S_PRE) || (state_d == S_ARMED) || (state_d == S_POST);
        done_d  = (state_d == S_DONE);
    end

    // State, counters and registered status flags
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q    <= S_IDLE;
            run_q      <= 1'b0;
            cnt_q      <= '0;
            sts_q      <= '0;
            win_q      <= '0;
            pre_len_q  <= '0;
            post_len_q <= '0;
            armed_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            cnt_q      <= cnt_d;
            sts_q      <= sts_d;
            win_q      <= win_d;
            pre_len_q  <= pre_len_d;
            post_len_q <= post_len_d;
            armed_q    <= armed_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign sts_data = sts_q;
    assign cnt_data = cnt_q;
    assign armed    = armed_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_axis_trigger_sequencer.sv
// Directed bench for axis_trigger_sequencer with a 4-bit ring address so that
// wrap-around is reachable in a handful of beats.
module tb_axis_trigger_sequencer;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          aclk = 1'b0;
    logic          areset;
    logic          run_flag;
    logic          trg_flag;
    logic [CW-1:0] pre_data;
    logic [CW-1:0] tot_data;
    logic [CW-1:0] sts_data;
    logic [CW-1:0] cnt_data;
    logic          armed;
    logic          busy;
    logic          done;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;

    int checks   = 0;
    int failures = 0;
    int fwd      = 0;
    int base;

    axis_trigger_sequencer #(
        .AXIS_TDATA_WIDTH(DW),
        .CNTR_WIDTH      (CW)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .run_flag     (run_flag),
        .trg_flag     (trg_flag),
        .pre_data     (pre_data),
        .tot_data     (tot_data),
        .sts_data     (sts_data),
        .cnt_data     (cnt_data),
        .armed        (armed),
        .busy         (busy),
        .done         (done),
        .s_axis_tready(s_axis_tready),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid)
    );

    always #5 aclk = ~aclk;

    // Count beats handed to the buffer writer, sampled mid-cycle
    always @(negedge aclk) begin
        if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) fwd++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic beat(input bit t);
        trg_flag = t;
        tick();
        trg_flag = 1'b0;
    endtask

    initial begin
        areset        = 1'b1;
        run_flag      = 1'b0;
        trg_flag      = 1'b0;
        pre_data      = '0;
        tot_data      = '0;
        s_axis_tdata  = 32'hA5A5_0001;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_armed", armed, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", cnt_data, 0);
        chk("rst_sts", sts_data, 0);
        chk("rst_mvalid", m_axis_tvalid, 0);
        chk("rst_sready", s_axis_tready, 1);
        tick();
        areset = 1'b0;
        tick();

        // Normal capture: P=4, tot=10, trigger on beat 7
        s_axis_tvalid = 1'b1;
        pre_data = 4'd4;
        tot_data = 4'd10;
        base = fwd;
        run_flag = 1'b1;
        tick();
        chk("n_pre_busy", busy, 1);
        chk("n_pre_armed", armed, 0);
        chk("n_tdata", m_axis_tdata, 32'hA5A5_0001);
        repeat (3) beat(0);
        chk("n_not_armed_b3", armed, 0);
        beat(0);
        chk("n_armed_b4", armed, 1);
        chk("n_cnt_b4", cnt_data, 4);
        beat(0);
        beat(0);
        beat(1);
        chk("n_sts", sts_data, 6);
        chk("n_post_armed", armed, 0);
        chk("n_cnt_b7", cnt_data, 7);
        repeat (4) beat(0);
        chk("n_done_b11", done, 0);
        beat(0);
        chk("n_done_b12", done, 1);
        chk("n_busy_done", busy, 0);
        chk("n_cnt_b12", cnt_data, 12);
        tick();
        chk("n_cnt_held", cnt_data, 12);
        chk("n_fwd", fwd - base, 12);
        chk("n_sready_done", s_axis_tready, 1);

        // Early trigger pulses in PRE (including the last PRE beat) are ignored
        run_flag = 1'b0;
        tick();
        pre_data = 4'd4;
        tot_data = 4'd10;
        run_flag = 1'b1;
        tick();
        chk("e_done_cleared", done, 0);
        chk("e_cnt_cleared", cnt_data, 0);
        beat(0);
        beat(1);
        beat(0);
        beat(1);
        chk("e_armed_b4", armed, 1);
        repeat (4) beat(0);
        chk("e_armed_b8", armed, 1);
        beat(1);
        chk("e_sts", sts_data, 8);
        chk("e_post", armed, 0);
        repeat (4) beat(0);
        chk("e_done_b13", done, 0);
        beat(0);
        chk("e_done_b14", done, 1);
        chk("e_cnt", cnt_data, 14);

        // Degenerate windows: P=0, tot=0
        run_flag = 1'b0;
        s_axis_tvalid = 1'b0;
        tick();
        pre_data = 4'd0;
        tot_data = 4'd0;
        run_flag = 1'b1;
        tick();
        chk("d_armed", armed, 1);
        chk("d_cnt", cnt_data, 0);
        base = fwd;
        beat(1);
        chk("d_trg_no_acc", armed, 1);
        s_axis_tvalid = 1'b1;
        beat(1);
        chk("d_done", done, 1);
        chk("d_sts", sts_data, 0);
        chk("d_cnt1", cnt_data, 1);
        tick();
        chk("d_fwd", fwd - base, 1);

        // Wrap-around: P=10, trigger 12 beats after armed, tot=15
        run_flag = 1'b0;
        tick();
        pre_data = 4'd10;
        tot_data = 4'd15;
        run_flag = 1'b1;
        tick();
        base = fwd;
        repeat (10) beat(0);
        chk("w_armed", armed, 1);
        chk("w_cnt10", cnt_data, 10);
        repeat (12) beat(0);
        chk("w_still_armed", armed, 1);
        chk("w_cnt_wrap", cnt_data, 6);
        beat(1);
        chk("w_sts", sts_data, 6);
        repeat (3) beat(0);
        chk("w_done_early", done, 0);
        beat(0);
        chk("w_done", done, 1);
        chk("w_cnt", cnt_data, 11);
        chk("w_fwd", fwd - base, 27);

        // Backpressure: stalled trigger missed, POST counts only accepted beats
        run_flag = 1'b0;
        tick();
        pre_data = 4'd2;
        tot_data = 4'd7;
        run_flag = 1'b1;
        tick();
        base = fwd;
        beat(0);
        beat(0);
        chk("b_armed", armed, 1);
        m_axis_tready = 1'b0;
        #1;
        chk("b_sready_stall", s_axis_tready, 0);
        beat(1);
        chk("b_trg_missed", armed, 1);
        chk("b_cnt_stall", cnt_data, 2);
        m_axis_tready = 1'b1;
        beat(1);
        chk("b_sts", sts_data, 2);
        chk("b_cnt3", cnt_data, 3);
        for (int i = 0; i < 6; i++) begin
            m_axis_tready = (i % 2 == 1);
            tick();
        end
        chk("b_done_early", done, 0);
        chk("b_cnt6", cnt_data, 6);
        m_axis_tready = 1'b0;
        tick();
        m_axis_tready = 1'b1;
        tick();
        chk("b_done", done, 1);
        chk("b_cnt7", cnt_data, 7);
        tick();
        chk("b_fwd", fwd - base, 7);

        // Abort while ARMED
        run_flag = 1'b0;
        tick();
        pre_data = 4'd3;
        tot_data = 4'd8;
        run_flag = 1'b1;
        tick();
        repeat (3) beat(0);
        chk("a_armed", armed, 1);
        run_flag = 1'b0;
        tick();
        chk("a_armed_low", armed, 0);
        chk("a_busy_low", busy, 0);
        chk("a_done_low", done, 0);
        chk("a_mvalid", m_axis_tvalid, 0);
        chk("a_sts_held", sts_data, 2);
        m_axis_tready = 1'b0;
        #1;
        chk("a_sready_drain", s_axis_tready, 1);
        m_axis_tready = 1'b1;

        // Asynchronous reset during POST
        pre_data = 4'd1;
        tot_data = 4'd5;
        run_flag = 1'b1;
        tick();
        beat(0);
        beat(1);
        chk("r_busy", busy, 1);
        chk("r_sts", sts_data, 1);
        #1;
        areset = 1'b1;
        #1;
        chk("r_busy0", busy, 0);
        chk("r_done0", done, 0);
        chk("r_cnt0", cnt_data, 0);
        chk("r_sts0", sts_data, 0);
        chk("r_mvalid0", m_axis_tvalid, 0);
        chk("r_sready1", s_axis_tready, 1);
        tick();
        areset = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
